// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 SRAM port arbiter.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  // Grant encoding doubles as the SRAM-side mux select.
  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DMA = 1'b1;

  localparam int DEF_ACCESS_CYCLES = 2;

endpackage

// File: rtl/mux_2to1.sv
// Generic 2:1 multiplexer; i_sel=0 picks i_a, i_sel=1 picks i_b.
module mux_2to1 #(
  parameter int W = 1
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one LC-3 SRAM port between the CPU (req0)
// and the display/DMA engine (req1). Latches the winner's request, holds
// mem_ce for ACCESS_CYCLES cycles, then returns read data with a one-cycle ack.
module mem_port_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  output logic             ack0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic             grant_sel,
  output logic             mem_ce,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  localparam int CW = 4;

  generate
    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_cycles
      $error("mem_port_arbiter: ACCESS_CYCLES must be within 1..15");
    end
  endgenerate

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_last_grant;
  logic             r_grant_sel;
  logic             r_we;
  logic [WIDTH-1:0] r_addr, r_wdata, r_rdata;

  logic             w_next_grant;
  logic             w_start;
  logic             w_done;
  logic [WIDTH-1:0] w_sel_addr, w_sel_wdata;
  logic             w_sel_we;

  // A lone requester always wins; on a tie the one not served last wins.
  assign w_next_grant = (req0 & req1) ? ~r_last_grant : req1;

  mux_2to1 #(.W(WIDTH)) u_mux_addr (
    .i_sel (w_next_grant),
    .i_a   (addr0),
    .i_b   (addr1),
    .o_y   (w_sel_addr)
  );

  mux_2to1 #(.W(WIDTH)) u_mux_wdata (
    .i_sel (w_next_grant),
    .i_a   (wdata0),
    .i_b   (wdata1),
    .o_y   (w_sel_wdata)
  );

  mux_2to1 #(.W(1)) u_mux_we (
    .i_sel (w_next_grant),
    .i_a   (we0),
    .i_b   (we1),
    .o_y   (w_sel_we)
  );

  // Next-state and access counter; requests are only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req0 | req1) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = CW'(ACCESS_CYCLES - 1);
          w_start     = 1'b1;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = ACK;
          w_done      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latch the winner at grant time so later input changes cannot disturb the access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last_grant <= GRANT_DMA;
      r_grant_sel  <= GRANT_CPU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_start) begin
      r_last_grant <= w_next_grant;
      r_grant_sel  <= w_next_grant;
      r_we         <= w_sel_we;
      r_addr       <= w_sel_addr;
      r_wdata      <= w_sel_wdata;
    end
  end

  // Capture SRAM data on the last access cycle; held until the next capture.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_rdata <= '0;
    else if (w_done) r_rdata <= mem_rdata;
  end

  assign mem_ce    = (r_state == ACCESS);
  assign mem_we    = (r_state == ACCESS) & r_we;
  assign busy      = (r_state != IDLE);
  assign ack0      = (r_state == ACK) & (r_grant_sel == GRANT_CPU);
  assign ack1      = (r_state == ACK) & (r_grant_sel == GRANT_DMA);
  assign grant_sel = r_grant_sel;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level scheduling model feeds a
// scoreboard queue, a negedge monitor checks every cycle against it.
module tb_mem_port_arbiter;

  localparam int AC = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
  logic        ack0, ack1, grant_sel, mem_ce, mem_we, busy;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  // second instance, ACCESS_CYCLES=1
  logic        b_req0 = 1'b0;
  logic [15:0] b_addr0 = '0;
  logic        b_zero = 1'b0;
  logic [15:0] b_zero16 = '0;
  logic [15:0] b_mem_rdata = 16'h7E57;
  logic        b_ack0, b_ack1, b_gsel, b_ce, b_we, b_busy;
  logic [15:0] b_rdata, b_maddr, b_mwdata;

  int total = 0;
  int bad = 0;

  bit          ov_en = 1'b1;
  logic [15:0] ov_val = 16'hBEEF;

  always #5 Clk = ~Clk;

  function automatic logic [15:0] hsh(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // SRAM stand-in: data is a fixed function of the presented address
  assign mem_rdata = ov_en ? ov_val : hsh(mem_addr);

  mem_port_arbiter #(.WIDTH(16), .ACCESS_CYCLES(AC)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .grant_sel(grant_sel), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.WIDTH(16), .ACCESS_CYCLES(1)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .req0(b_req0), .we0(b_zero), .addr0(b_addr0), .wdata0(b_zero16), .ack0(b_ack0),
    .req1(b_zero), .we1(b_zero), .addr1(b_zero16), .wdata1(b_zero16), .ack1(b_ack1),
    .rdata(b_rdata), .grant_sel(b_gsel), .mem_ce(b_ce), .mem_we(b_we),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: who owns the port, and when ----------
  typedef struct {
    bit          who;
    int          e;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] rd;
    bit          we;
  } txn_t;

  txn_t        q[$];
  txn_t        mt, ct;
  int          cyc = 0;
  int          free_at = 0;
  bit          last_m = 1'b1;
  logic [15:0] hold_a = '0, hold_d = '0, hold_rd = '0;
  int          L;

  // Port is free again AC+2 edges after a grant; ties go to whoever was not served last.
  initial forever begin
    @(posedge Clk);
    if (!Reset_n) begin
      q.delete();
      free_at = cyc + 1;
      last_m  = 1'b1;
      hold_a  = '0;
      hold_d  = '0;
      hold_rd = '0;
    end else if (cyc >= free_at && (req0 || req1)) begin
      mt.who = (req0 && req1) ? !last_m : req1;
      mt.e   = cyc;
      mt.a   = mt.who ? addr1 : addr0;
      mt.d   = mt.who ? wdata1 : wdata0;
      mt.we  = mt.who ? we1 : we0;
      mt.rd  = ov_en ? ov_val : hsh(mt.a);
      q.push_back(mt);
      last_m  = mt.who;
      free_at = cyc + AC + 2;
      hold_a  = mt.a;
      hold_d  = mt.d;
    end
    cyc++;
  end

  // Monitor: every cycle is either inside a scheduled access, its ack, or idle.
  initial forever begin
    @(negedge Clk);
    if (Reset_n) begin
      L = cyc - 1;
      if (q.size() > 0) begin
        ct = q[0];
        if (L < ct.e + AC) begin
          chk("acc_ce", mem_ce, 1);
          chk("acc_we", mem_we, ct.we);
          chk("acc_addr", mem_addr, ct.a);
          chk("acc_wdata", mem_wdata, ct.d);
          chk("acc_gsel", grant_sel, ct.who);
          chk("acc_busy", busy, 1);
          chk("acc_noack", {ack1, ack0}, 0);
        end else begin
          chk("ack_pair", {ack1, ack0}, ct.who ? 2'b10 : 2'b01);
          chk("ack_rdata", rdata, ct.rd);
          chk("ack_ce", {mem_ce, mem_we}, 0);
          chk("ack_busy", busy, 1);
          hold_rd = ct.rd;
          void'(q.pop_front());
        end
      end else begin
        chk("idle_ack", {ack1, ack0}, 0);
        chk("idle_ce", mem_ce, 0);
        chk("idle_busy", busy, 0);
        chk("idle_addr", mem_addr, hold_a);
        chk("idle_wdata", mem_wdata, hold_d);
        chk("idle_rdata", rdata, hold_rd);
      end
    end
  end

  // ---------------- requester driver ---------------------------------------
  // scr: 0 hold inputs, 1 force addr to FFFF while waiting, 2 randomise inputs while waiting
  task automatic issue(input bit k, input bit we, input logic [15:0] a,
                       input logic [15:0] d, input int scr);
    int n;
    @(negedge Clk);
    if (k) begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    n = 0;
    forever begin
      @(negedge Clk);
      n++;
      if (k ? ack1 : ack0) break;
      if (n > 60) begin
        total++;
        bad++;
        $display("FAIL ack_timeout: requester %0d got no ack, want ack within 60 cycles", k);
        break;
      end
      if (scr == 1) begin
        if (k) addr1 = 16'hFFFF; else addr0 = 16'hFFFF;
      end else if (scr == 2 && $urandom_range(0, 1) == 1) begin
        if (k) begin addr1 = 16'($urandom); wdata1 = 16'($urandom); we1 = 1'($urandom); end
        else   begin addr0 = 16'($urandom); wdata0 = 16'($urandom); we0 = 1'($urandom); end
      end
    end
    if (k) req1 = 0; else req0 = 0;
  endtask

  task automatic driver(input bit k, input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      issue(k, 1'($urandom), 16'($urandom), 16'($urandom), 2);
    end
  endtask

  // Reset in the second access cycle of requester k's access
  task automatic rst_mid(input bit k);
    @(negedge Clk);
    if (k) begin req1 = 1; we1 = 1; addr1 = 16'h0CDE; wdata1 = 16'h7777; end
    else   begin req0 = 1; we0 = 0; addr0 = 16'h0ABC; end
    @(posedge Clk);
    @(posedge Clk);
    #2 Reset_n = 0;
    #1;
    chk("rst_ce", mem_ce, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gsel", grant_sel, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    req0 = 0;
    req1 = 0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1;
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    repeat (2) @(negedge Clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_mem_ce", mem_ce, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy0", busy, 0);
    chk("rst_grant_sel", grant_sel, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rdata0", rdata, 0);
    Reset_n = 1;

    // single CPU read returning BEEF
    issue(0, 0, 16'h3000, 16'h0000, 0);
    ov_en = 0;
    // single DMA write
    issue(1, 1, 16'h4001, 16'h1234, 0);
    // continuous contention
    fork
      repeat (4) issue(0, 0, 16'h1000, 16'h0001, 0);
      repeat (4) issue(1, 1, 16'h2000, 16'h0002, 0);
    join
    // req1 arrives mid-access, addr0 scribbled after grant
    fork
      issue(0, 0, 16'h2222, 16'h0303, 1);
      begin
        repeat (2) @(negedge Clk);
        issue(1, 0, 16'h5555, 16'h0404, 0);
      end
    join
    // randomized traffic
    fork
      driver(0, 20);
      driver(1, 20);
    join
    repeat (3) @(negedge Clk);

    // reset mid-access, then tie after release must go to req0
    rst_mid(1);
    repeat (2) @(negedge Clk);
    rst_mid(0);
    fork
      issue(0, 0, 16'h0042, 16'h0000, 0);
      issue(1, 0, 16'h0043, 16'h0000, 0);
    join
    repeat (3) @(negedge Clk);

    // ACCESS_CYCLES=1 instance
    @(negedge Clk);
    b_req0 = 1;
    b_addr0 = 16'h0123;
    @(negedge Clk);
    chk("ac1_ce", b_ce, 1);
    chk("ac1_addr", b_maddr, 16'h0123);
    chk("ac1_early_ack", b_ack0, 0);
    @(negedge Clk);
    chk("ac1_ack", b_ack0, 1);
    chk("ac1_rdata", b_rdata, 16'h7E57);
    chk("ac1_ce_off", b_ce, 0);
    chk("ac1_ack1", b_ack1, 0);
    b_req0 = 0;
    @(negedge Clk);
    chk("ac1_ack_done", b_ack0, 0);
    chk("ac1_idle_busy", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single LC-3 SRAM port between two requesters: req0 is the CPU MAR/MDR path and req1 is the display/DMA fetch engine. The block arbitrates round-robin and latches the winner's address, write data and write enable. It sequences a fixed-length memory access, returns read data and pulses a one-cycle acknowledge. It also drives grant_sel, the select line of the address/data multiplexer in front of the SRAM port.

Parameters:
WIDTH, 16, address and data width.
ACCESS_CYCLES, 2, cycles mem_ce is held per access; legal range 1..15.

Ports:
Clk  in  1  system clock, rising-edge.
Reset_n  in  1  asynchronous active-low reset.
req0  in  1  CPU request; held high until ack0.
we0  in  1  CPU write enable (1 = write).
addr0  in  WIDTH  CPU address.
wdata0  in  WIDTH  CPU write data.
ack0  out  1  one-cycle completion pulse to CPU.
req1  in  1  display/DMA request; held high until ack1.
we1  in  1  display/DMA write enable.
addr1  in  WIDTH  display/DMA address.
wdata1  in  WIDTH  display/DMA write data.
ack1  out  1  one-cycle completion pulse to display/DMA.
rdata  out  WIDTH  read data; valid while ack0 or ack1 is high, held afterwards.
grant_sel  out  1  select of the SRAM-side mux: 1 = requester 1, 0 = requester 0.
mem_ce  out  1  SRAM chip enable, active high.
mem_we  out  1  SRAM write enable, active high.
mem_addr  out  WIDTH  latched SRAM address.
mem_wdata  out  WIDTH  latched SRAM write data.
mem_rdata  in  WIDTH  SRAM read data.
busy  out  1  high in ACCESS and ACK.

Behaviour:
- Interface: one clock, Clk. Reset_n is asynchronous and active-low; assertion takes effect immediately, independent of Clk.
- Reset values: state=IDLE; last_grant=1, so requester 0 wins the first tie. ack0, ack1, mem_ce, mem_we, busy and grant_sel are 0. mem_addr, mem_wdata and rdata are 0. Counter is 0.
- States:
  - IDLE: if no request, stay in IDLE.
  - IDLE -> ACCESS on a single request: grant that requester.
  - IDLE -> ACCESS on simultaneous req0 and req1: grant the requester not equal to last_grant.
  - IDLE -> ACCESS edge actions: latch grant_sel, addr, wdata and we of the winner; set last_grant=winner; load counter=ACCESS_CYCLES-1.
- ACCESS:
  - mem_ce=1; mem_we = latched we.
  - Counter decrements each cycle.
  - When counter==0: capture mem_rdata into rdata (also on writes) and go to ACK.
- ACK:
  - The winner's ack is 1 for exactly this cycle; mem_ce=0 and mem_we=0.
  - Always returns to IDLE next cycle.
- Latency: a request sampled in IDLE at edge E produces ack high in cycle E+ACCESS_CYCLES+1. Minimum request-to-request spacing per requester is ACCESS_CYCLES+2 cycles.
- Requester inputs are ignored outside IDLE. Changes to addr/wdata/we mid-access have no effect because those values are latched.
- Requester rule: drop req on the edge that samples ack. A req still high in IDLE is a new request.
- Fairness: under continuous contention, grants alternate 0,1,0,1.
- A request arriving during another's access waits. It wins in the next IDLE only under round-robin rules.
- ack0 and ack1 are never high together.
- mem_addr and mem_wdata hold their last values in IDLE.
- Reset mid-access: all outputs return immediately to reset values. The in-flight access is abandoned with no ack.
- ACCESS_CYCLES outside 1..15 fails an elaboration-time assertion.

Decomposition:
- Package lc3_mem_pkg holds:
  - state enum {IDLE, ACCESS, ACK};
  - grant constants GRANT_CPU=1'b0 and GRANT_DMA=1'b1;
  - ACCESS_CYCLES default constant.
- The latch-side address/data/we selection reuses mux_2to1 instances (WIDTH for addr/wdata, 1 for we), driven by the next-grant signal.
- No new sub-module; FSM, counter and round-robin pointer live in this block.

Test Plan:
1. Reset, then req0=1, we0=0, addr0=0x3000, mem_rdata=0xBEEF -> grant_sel=0, mem_ce high 2 cycles, ack0 pulses in cycle 3 with rdata=0xBEEF, ack1 stays 0.
2. req1=1, we1=1, addr1=0x4001, wdata1=0x1234 -> mem_we=1, mem_addr=0x4001 and mem_wdata=0x1234 during ACCESS; single ack1 pulse.
3. req0 and req1 both high from reset and held continuously (re-raised the cycle after ack) -> grant order 0,1,0,1; one ack per 4 cycles; ack0 and ack1 never overlap.
4. req1 arrives during a req0 ACCESS, with addr0 changed to 0xFFFF mid-access -> mem_addr keeps the original address; req1 is granted in the next IDLE.
5. Reset_n pulled low in the second ACCESS cycle -> mem_ce, busy and grant_sel drop immediately with no ack; after release, req0 wins the first tie.
6. ACCESS_CYCLES=1 build, single req0 -> ack0 two cycles after the request is sampled.
